cle_label_packer: RTL and testbench

CLE_LABEL_PACKER -- requirements
Module: cle_label_packer

---
 rtl/cle_label_packer.sv | 112 +++++++++++
 tb/tb_cle_label_packer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/cle_label_packer.sv
// Repacks the 1024x8 CLE label SRAM into 128 MSB-first bitmap bytes; optional area counter under CLE_AREA_COUNT_EN.
// Latency: first byte 9 cycles after start, 10 cycles/byte; out_ready=0 parks the block in EMIT with no SRAM reads.
module cle_label_packer (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] target,
   input  logic [7:0] sram_q,
   output logic [9:0] sram_a,
   output logic       sram_wen,
   output logic [7:0] out_data,
   output logic [6:0] out_addr,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       busy,
   output logic       done
`ifdef CLE_AREA_COUNT_EN
   ,output logic [9:0] area
`endif
);

   typedef enum logic [2:0] {IDLE, READ, LAST, EMIT, DONE} state_t;

   state_t     state, state_nxt;
   logic [7:0] tgt_q;
   logic [6:0] byte_q;
   logic [2:0] pix_q;
   logic [7:0] shreg;
   logic       match;

   // Target 0 means "any labelled pixel"; sram_q belongs to the previous cycle's address.
   assign match    = (tgt_q != 8'd0) ? (sram_q == tgt_q) : (sram_q != 8'd0);
   assign sram_wen = 1'b1;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         tgt_q    <= 8'd0;
         byte_q   <= 7'd0;
         pix_q    <= 3'd0;
         shreg    <= 8'd0;
         out_data <= 8'd0;
         out_addr <= 7'd0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: if (start) begin
               tgt_q  <= target;
               byte_q <= 7'd0;
               pix_q  <= 3'd0;
            end
            READ: begin
               shreg <= {shreg[6:0], match};
               pix_q <= pix_q + 3'd1;
            end
            LAST: begin
               // shreg[7] holds the stale bit shifted in on pix 0; it drops out here.
               out_data <= {shreg[6:0], match};
               out_addr <= byte_q;
            end
            EMIT: if (out_ready && byte_q != 7'd127) begin
               byte_q <= byte_q + 7'd1;
               pix_q  <= 3'd0;
            end
            default: ;
         endcase
      end
   end

`ifdef CLE_AREA_COUNT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         area <= 10'd0;
      end else if (state == IDLE && start) begin
         area <= 10'd0;
      end else if ((state == READ && pix_q != 3'd0) || state == LAST) begin
         area <= area + {9'd0, match};
      end
   end
`endif

   always_comb begin
      state_nxt = state;
      sram_a    = 10'd0;
      out_valid = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: if (start) state_nxt = READ;
         READ: begin
            busy   = 1'b1;
            sram_a = {byte_q, pix_q};
            if (pix_q == 3'd7) state_nxt = LAST;
         end
         LAST: begin
            busy      = 1'b1;
            state_nxt = EMIT;
         end
         EMIT: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) state_nxt = (byte_q == 7'd127) ? DONE : READ;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_cle_label_packer.sv
// Self-checking bench for cle_label_packer: vector table, random images vs a per-pixel model, stall/reset/restart sequences.
module tb_cle_label_packer;

   logic       clk = 1'b0;
   logic       reset, start, out_ready;
   logic [7:0] target, sram_q;
   logic [9:0] sram_a;
   logic       sram_wen;
   logic [7:0] out_data;
   logic [6:0] out_addr;
   logic       out_valid, busy, done;
`ifdef CLE_AREA_COUNT_EN
   logic [9:0] area;
`endif

   cle_label_packer dut (
      .clk(clk), .reset(reset), .start(start), .target(target), .sram_q(sram_q),
      .sram_a(sram_a), .sram_wen(sram_wen), .out_data(out_data), .out_addr(out_addr),
      .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done)
`ifdef CLE_AREA_COUNT_EN
      , .area(area)
`endif
   );

   always #5 clk = ~clk;

   logic [7:0] mem [0:1023];
   always @(posedge clk) sram_q <= mem[sram_a];

   int errors = 0;
   int checks = 0;

   logic [7:0] got [128];
   int n_acc, first_valid, done_cyc, done_cnt, order_err, stall_err, stall_cnt, busy_err;
   logic [9:0] area_at_done;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] model_byte(input int k, input logic [7:0] tgt);
      logic [7:0] b;
      logic [7:0] p;
      for (int i = 0; i < 8; i++) begin
         p = mem[8*k + i];
         b[7-i] = (tgt != 8'd0) ? (p == tgt) : (p != 8'd0);
      end
      return b;
   endfunction

   function automatic logic [9:0] model_area(input logic [7:0] tgt);
      int n = 0;
      for (int i = 0; i < 1024; i++)
         if ((tgt != 8'd0) ? (mem[i] == tgt) : (mem[i] != 8'd0)) n++;
      return n[9:0];
   endfunction

   task automatic load_image(input int img);
      for (int i = 0; i < 1024; i++) mem[i] = 8'd0;
      if (img == 1) begin
         mem[0] = 8'h01; mem[9] = 8'h01; mem[1023] = 8'h02;
      end
   endtask

   // Drives one scan; stall_byte<0 disables stalling, restart_cyc<0 disables the mid-scan start pulse.
   task automatic run_scan(input logic [7:0] tgt, input int stall_byte, input int restart_cyc, input logic [7:0] alt);
      int cyc;
      int post;
      logic [7:0] held;
      n_acc = 0; first_valid = -1; done_cyc = -1; done_cnt = 0;
      order_err = 0; stall_err = 0; stall_cnt = 0; busy_err = 0;
      held = 8'd0;
      @(negedge clk);
      target = tgt; start = 1'b1; out_ready = 1'b1;
      cyc = 0; post = -1;
      while (cyc < 3000 && post != 0) begin
         @(negedge clk);
         start = (cyc == restart_cyc);
         if (cyc == restart_cyc) target = alt;
         if (out_valid && first_valid < 0) first_valid = cyc;
         if (out_valid && sram_a != 10'd0) stall_err++;
         if (cyc == 0 && !busy) busy_err++;
         if (done) begin
            done_cnt++;
            if (busy) busy_err++;
            if (done_cyc < 0) begin
               done_cyc = cyc;
               post = 4;
`ifdef CLE_AREA_COUNT_EN
               area_at_done = area;
`endif
            end
         end
         if (post > 0) post--;
         if (out_valid && int'(out_addr) == stall_byte && stall_cnt < 5) begin
            if (stall_cnt > 0 && out_data !== held) stall_err++;
            held = out_data;
            stall_cnt++;
            out_ready = 1'b0;
         end else begin
            out_ready = 1'b1;
         end
         if (out_valid && out_ready) begin
            if (int'(out_addr) != n_acc) order_err++;
            if (n_acc < 128) got[n_acc] = out_data;
            n_acc++;
         end
         cyc++;
      end
      start = 1'b0; out_ready = 1'b1;
      if (done_cyc < 0) chk("scan_timeout", 0, 1);
   endtask

   task automatic check_scan(input string name, input logic [7:0] tgt, input int exp_done);
      int bad = 0;
      chk({name, "_nbytes"}, n_acc, 128);
      chk({name, "_addr_order"}, order_err, 0);
      chk({name, "_stall_hold"}, stall_err, 0);
      chk({name, "_first_valid"}, first_valid, 9);
      chk({name, "_done_cycle"}, done_cyc, exp_done);
      chk({name, "_done_width"}, done_cnt, 1);
      chk({name, "_busy"}, busy_err, 0);
      for (int k = 0; k < 128; k++)
         if (k < n_acc && got[k] !== model_byte(k, tgt)) begin
            bad++;
            if (bad < 4) chk({name, "_byte"}, {24'd0, got[k]}, {24'd0, model_byte(k, tgt)});
         end
      chk({name, "_bytes_bad"}, bad, 0);
`ifdef CLE_AREA_COUNT_EN
      chk({name, "_area"}, area_at_done, model_area(tgt));
`endif
   endtask

   typedef struct {
      int         img;
      logic [7:0] tgt;
      logic [7:0] b0, b1, b127;
      int         area;
   } vec_t;

   vec_t vecs [4];

   initial begin
      int found;
      vecs[0] = '{img: 0, tgt: 8'h00, b0: 8'h00, b1: 8'h00, b127: 8'h00, area: 0};
      vecs[1] = '{img: 1, tgt: 8'h01, b0: 8'h80, b1: 8'h40, b127: 8'h00, area: 2};
      vecs[2] = '{img: 1, tgt: 8'h00, b0: 8'h80, b1: 8'h40, b127: 8'h01, area: 3};
      vecs[3] = '{img: 1, tgt: 8'h02, b0: 8'h00, b1: 8'h00, b127: 8'h01, area: 1};

      load_image(0);
      reset = 1'b1; start = 1'b0; target = 8'h00; out_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0);
      chk("rst_addr", out_addr, 0);
      chk("rst_sram_a", sram_a, 0);
      chk("rst_wen", sram_wen, 1);
`ifdef CLE_AREA_COUNT_EN
      chk("rst_area", area, 0);
`endif
      // reset wins over a simultaneous start
      start = 1'b1;
      @(negedge clk);
      start = 1'b0; reset = 1'b0;
      @(negedge clk);
      chk("rst_prio_busy", busy, 0);

      foreach (vecs[v]) begin
         load_image(vecs[v].img);
         run_scan(vecs[v].tgt, -1, -1, 8'h00);
         chk($sformatf("vec%0d_b0", v), got[0], vecs[v].b0);
         chk($sformatf("vec%0d_b1", v), got[1], vecs[v].b1);
         chk($sformatf("vec%0d_b127", v), got[127], vecs[v].b127);
`ifdef CLE_AREA_COUNT_EN
         chk($sformatf("vec%0d_area", v), area_at_done, vecs[v].area);
`endif
         check_scan($sformatf("vec%0d", v), vecs[v].tgt, 1280);
      end

      for (int r = 0; r < 3; r++) begin
         logic [7:0] t;
         for (int i = 0; i < 1024; i++)
            mem[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 3)) : 8'd0;
         t = 8'($urandom_range(0, 3));
         run_scan(t, -1, -1, 8'h00);
         check_scan($sformatf("rand%0d", r), t, 1280);
      end

      load_image(1);
      run_scan(8'h01, 3, -1, 8'h00);
      chk("stall_len", stall_cnt, 5);
      check_scan("stall", 8'h01, 1285);

      run_scan(8'h01, -1, 200, 8'h02);
      check_scan("restart", 8'h01, 1280);

      // reset in the middle of byte 40's read burst
      @(negedge clk);
      target = 8'h01; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      found = 0;
      for (int c = 0; c < 1000 && found == 0; c++) begin
         if (busy && sram_a == {7'd40, 3'd2}) found = 1;
         else @(negedge clk);
      end
      chk("rstmid_reached", found, 1);
      reset = 1'b1;
      @(negedge clk);
      chk("rstmid_valid", out_valid, 0);
      chk("rstmid_busy", busy, 0);
      chk("rstmid_sram_a", sram_a, 0);
      reset = 1'b0;
      repeat (20) @(negedge clk);
      chk("rstmid_stay_idle", busy, 0);
      run_scan(8'h01, -1, -1, 8'h00);
      chk("rstmid_first_byte", got[0], 8'h80);
      check_scan("rstmid", 8'h01, 1280);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
